csel_mod_adder_pipe: RTL and testbench

//  Pipelined carry-select modular adder; throughput one result per cycle.

---
 rtl/csel_mod_adder_pipe.sv | 192 +++++++++++++++++++
 tb/tb_csel_mod_adder_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/csel_mod_adder_pipe.sv
// Pipelined carry-select modular adder: one block of BLOCK bits is resolved per stage
// for both a+b and a+b-p; the last stage picks the reduced or raw sum.
module csel_mod_adder_pipe #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  input  logic             mod_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] s_raw,
  output logic             c_out,
  output logic             wrap
);
  localparam int NBLK = WIDTH / BLOCK;

  function automatic logic [WIDTH-1:0] maj3(input logic [WIDTH-1:0] u,
                                            input logic [WIDTH-1:0] v,
                                            input logic [WIDTH-1:0] w);
    return (u & v) | (u & w) | (v & w);
  endfunction

  // Both carry-in variants are formed; the registered carry only selects between them.
  function automatic logic [BLOCK:0] blk_add(input logic [BLOCK-1:0] u,
                                             input logic [BLOCK-1:0] v,
                                             input logic             cin);
    logic [BLOCK:0] sum0;
    logic [BLOCK:0] sum1;
    sum0 = {1'b0, u} + {1'b0, v};
    sum1 = sum0 + {{BLOCK{1'b0}}, 1'b1};
    return cin ? sum1 : sum0;
  endfunction

  logic             adv;
  logic [WIDTH-1:0] p_inv;
  logic [WIDTH-1:0] maj_in;
  logic [WIDTH-1:0] x_in;
  logic [WIDTH-1:0] y_in;
  logic             m_in;
  logic             ge;

  logic [WIDTH-1:0] a_q   [NBLK];
  logic [WIDTH-1:0] b_q   [NBLK];
  logic [WIDTH-1:0] x_q   [NBLK];
  logic [WIDTH-1:0] y_q   [NBLK];
  logic [WIDTH-1:0] r1_q  [NBLK];
  logic [WIDTH-1:0] r2_q  [NBLK];
  logic [NBLK-1:0]  vld_q;
  logic [NBLK-1:0]  c1_q;
  logic [NBLK-1:0]  c2_q;
  logic [NBLK-1:0]  m_q;
  logic [NBLK-1:0]  me_q;

  logic [WIDTH-1:0] a_d   [NBLK];
  logic [WIDTH-1:0] b_d   [NBLK];
  logic [WIDTH-1:0] x_d   [NBLK];
  logic [WIDTH-1:0] y_d   [NBLK];
  logic [WIDTH-1:0] r1_d  [NBLK];
  logic [WIDTH-1:0] r2_d  [NBLK];
  logic [NBLK-1:0]  vld_d;
  logic [NBLK-1:0]  c1_d;
  logic [NBLK-1:0]  c2_d;
  logic [NBLK-1:0]  m_d;
  logic [NBLK-1:0]  me_d;

  logic [WIDTH-1:0] a_src  [NBLK];
  logic [WIDTH-1:0] b_src  [NBLK];
  logic [WIDTH-1:0] x_src  [NBLK];
  logic [WIDTH-1:0] y_src  [NBLK];
  logic [WIDTH-1:0] r1_src [NBLK];
  logic [WIDTH-1:0] r2_src [NBLK];
  logic [NBLK-1:0]  vld_src;
  logic [NBLK-1:0]  c1_src;
  logic [NBLK-1:0]  c2_src;
  logic [NBLK-1:0]  m_src;
  logic [NBLK-1:0]  me_src;

  // Carry-save compression of a + b + ~p; the forced LSB of y is the +1 of -p.
  always_comb begin
    p_inv  = ~p;
    maj_in = maj3(a, b, p_inv);
    x_in   = a ^ b ^ p_inv;
    y_in   = {maj_in[WIDTH-2:0], 1'b1};
    m_in   = maj_in[WIDTH-1];
  end

  // Stage sources: stage 0 reads the input beat, stage k reads stage k-1 registers.
  always_comb begin
    a_src[0]   = a;
    b_src[0]   = b;
    x_src[0]   = x_in;
    y_src[0]   = y_in;
    r1_src[0]  = {WIDTH{1'b0}};
    r2_src[0]  = {WIDTH{1'b0}};
    vld_src[0] = in_valid;
    c1_src[0]  = 1'b0;
    c2_src[0]  = 1'b0;
    m_src[0]   = m_in;
    me_src[0]  = mod_en;
    for (int k = 1; k < NBLK; k++) begin
      a_src[k]   = a_q[k-1];
      b_src[k]   = b_q[k-1];
      x_src[k]   = x_q[k-1];
      y_src[k]   = y_q[k-1];
      r1_src[k]  = r1_q[k-1];
      r2_src[k]  = r2_q[k-1];
      vld_src[k] = vld_q[k-1];
      c1_src[k]  = c1_q[k-1];
      c2_src[k]  = c2_q[k-1];
      m_src[k]   = m_q[k-1];
      me_src[k]  = me_q[k-1];
    end
  end

  // Stage k resolves block k of both chains and forwards everything else unchanged.
  always_comb begin : resolve
    logic [BLOCK:0] t1;
    logic [BLOCK:0] t2;
    t1 = {(BLOCK+1){1'b0}};
    t2 = {(BLOCK+1){1'b0}};
    for (int k = 0; k < NBLK; k++) begin
      t1 = blk_add(a_src[k][k*BLOCK +: BLOCK], b_src[k][k*BLOCK +: BLOCK], c1_src[k]);
      t2 = blk_add(x_src[k][k*BLOCK +: BLOCK], y_src[k][k*BLOCK +: BLOCK], c2_src[k]);
      a_d[k]   = a_src[k];
      b_d[k]   = b_src[k];
      x_d[k]   = x_src[k];
      y_d[k]   = y_src[k];
      r1_d[k]  = r1_src[k];
      r2_d[k]  = r2_src[k];
      r1_d[k][k*BLOCK +: BLOCK] = t1[BLOCK-1:0];
      r2_d[k][k*BLOCK +: BLOCK] = t2[BLOCK-1:0];
      vld_d[k] = vld_src[k];
      c1_d[k]  = t1[BLOCK];
      c2_d[k]  = t2[BLOCK];
      m_d[k]   = m_src[k];
      me_d[k]  = me_src[k];
    end
  end

  // Pipeline registers; the whole pipe shifts together on adv, bubbles included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NBLK; k++) begin
        a_q[k]   <= {WIDTH{1'b0}};
        b_q[k]   <= {WIDTH{1'b0}};
        x_q[k]   <= {WIDTH{1'b0}};
        y_q[k]   <= {WIDTH{1'b0}};
        r1_q[k]  <= {WIDTH{1'b0}};
        r2_q[k]  <= {WIDTH{1'b0}};
        vld_q[k] <= 1'b0;
        c1_q[k]  <= 1'b0;
        c2_q[k]  <= 1'b0;
        m_q[k]   <= 1'b0;
        me_q[k]  <= 1'b0;
      end
    end else if (adv) begin
      for (int k = 0; k < NBLK; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        x_q[k]   <= x_d[k];
        y_q[k]   <= y_d[k];
        r1_q[k]  <= r1_d[k];
        r2_q[k]  <= r2_d[k];
        vld_q[k] <= vld_d[k];
        c1_q[k]  <= c1_d[k];
        c2_q[k]  <= c2_d[k];
        m_q[k]   <= m_d[k];
        me_q[k]  <= me_d[k];
      end
    end
  end

  // a+b >= p exactly when a+b-p+2^WIDTH overflows: chain-2 carry or the dropped top weight.
  always_comb begin
    out_valid = vld_q[NBLK-1];
    adv       = !out_valid | out_ready;
    in_ready  = adv;
    ge        = c2_q[NBLK-1] | m_q[NBLK-1];
    wrap      = me_q[NBLK-1] & ge;
    s_raw     = r1_q[NBLK-1];
    c_out     = c1_q[NBLK-1];
    s         = wrap ? r2_q[NBLK-1] : r1_q[NBLK-1];
  end

endmodule

// File: tb/tb_csel_mod_adder_pipe.sv
// Bench for csel_mod_adder_pipe: three instances (32/8, 16/16, 64/4) exercised in turn,
// checked against an arithmetic model of (a+b) mod p with a scoreboard queue.
module tb_csel_mod_adder_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] s;
    logic [63:0] raw;
    logic        c;
    logic        wrap;
  } exp_t;

  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] a_t, b_t, p_t;
  logic        me_t;
  int          sel;
  int          w_cur, lat_cur;
  int          npass = 0, nfail = 0, ntot = 0, nrecv = 0;
  logic        stall_prev = 1'b0;
  exp_t        sb[$];

  logic        iv0, iv1, iv2;
  logic        ir0, ir1, ir2, ov0, ov1, ov2, c0, c1, c2, wr0, wr1, wr2;
  logic [31:0] s0, raw0;
  logic [15:0] s1, raw1;
  logic [63:0] s2, raw2;
  logic        ir_o, ov_o, c_o, wr_o;
  logic [63:0] s_o, raw_o;

  assign iv0 = in_valid && (sel == 0);
  assign iv1 = in_valid && (sel == 1);
  assign iv2 = in_valid && (sel == 2);

  csel_mod_adder_pipe #(.WIDTH(32), .BLOCK(8)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .a(a_t[31:0]), .b(b_t[31:0]),
    .p(p_t[31:0]), .mod_en(me_t), .out_valid(ov0), .out_ready(out_ready), .s(s0),
    .s_raw(raw0), .c_out(c0), .wrap(wr0));
  csel_mod_adder_pipe #(.WIDTH(16), .BLOCK(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a_t[15:0]), .b(b_t[15:0]),
    .p(p_t[15:0]), .mod_en(me_t), .out_valid(ov1), .out_ready(out_ready), .s(s1),
    .s_raw(raw1), .c_out(c1), .wrap(wr1));
  csel_mod_adder_pipe #(.WIDTH(64), .BLOCK(4)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a_t), .b(b_t),
    .p(p_t), .mod_en(me_t), .out_valid(ov2), .out_ready(out_ready), .s(s2),
    .s_raw(raw2), .c_out(c2), .wrap(wr2));

  always_comb begin
    case (sel)
      1: begin ir_o = ir1; ov_o = ov1; s_o = {48'd0, s1}; raw_o = {48'd0, raw1}; c_o = c1; wr_o = wr1; end
      2: begin ir_o = ir2; ov_o = ov2; s_o = s2; raw_o = raw2; c_o = c2; wr_o = wr2; end
      default: begin ir_o = ir0; ov_o = ov0; s_o = {32'd0, s0}; raw_o = {32'd0, raw0}; c_o = c0; wr_o = wr0; end
    endcase
  end

  function automatic logic [63:0] mask_of(input int w);
    return (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  // Reference: plain integer arithmetic on a WIDTH-bit sum.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] p, input logic me, input int w);
    logic [64:0] sum;
    logic [63:0] m;
    exp_t e;
    m      = mask_of(w);
    sum    = {1'b0, a} + {1'b0, b};
    e.raw  = sum[63:0] & m;
    e.c    = sum[w];
    e.wrap = me && (sum >= {1'b0, p});
    e.s    = e.wrap ? ((sum[63:0] - p) & m) : e.raw;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_sel(input int k);
    sel     = k;
    w_cur   = (k == 1) ? 16 : ((k == 2) ? 64 : 32);
    lat_cur = (k == 1) ? 1 : ((k == 2) ? 16 : 4);
  endtask

  task automatic rnd_ops();
    logic [63:0] m;
    m    = mask_of(w_cur);
    p_t  = {$urandom, $urandom} & m;
    if (p_t == 64'd0) p_t = 64'd1;
    a_t  = {$urandom, $urandom} % p_t;
    b_t  = {$urandom, $urandom} % p_t;
    me_t = ($urandom_range(1, 0) == 1);
  endtask

  // One clock cycle, entered and left just after a falling edge.
  task automatic cyc(input logic v, input logic r, output logic acc);
    exp_t e;
    in_valid  = v;
    out_ready = r;
    #1;
    chk("in_ready_eq_adv", 64'(ir_o), 64'(!ov_o | r));
    if (stall_prev) chk("stall_keeps_valid", 64'(ov_o), 64'd1);
    if (ov_o) begin
      chk("sb_nonempty_on_valid", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb[0];
        chk("out_s", s_o, e.s);
        chk("out_raw", raw_o, e.raw);
        chk("out_c", 64'(c_o), 64'(e.c));
        chk("out_wrap", 64'(wr_o), 64'(e.wrap));
      end
    end
    acc = v & ir_o;
    if (acc) sb.push_back(model(a_t, b_t, p_t, me_t, w_cur));
    if (ov_o && r && sb.size() > 0) begin
      void'(sb.pop_front());
      nrecv++;
    end
    stall_prev = ov_o & !r;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic directed(input logic [63:0] a, input logic [63:0] b, input logic [63:0] p,
                          input logic me, input logic [63:0] want_s, input logic want_wrap);
    logic acc;
    a_t = a; b_t = b; p_t = p; me_t = me;
    chk("dir_pipe_empty", 64'(sb.size()), 64'd0);
    cyc(1'b1, 1'b1, acc);
    chk("dir_accept", 64'(acc), 64'd1);
    for (int i = 1; i < lat_cur; i++) begin
      chk("dir_lat_early", 64'(ov_o), 64'd0);
      cyc(1'b0, 1'b1, acc);
    end
    chk("dir_lat_valid", 64'(ov_o), 64'd1);
    chk("dir_hand_s", s_o, want_s);
    chk("dir_hand_wrap", 64'(wr_o), 64'(want_wrap));
    cyc(1'b0, 1'b1, acc);
    chk("dir_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic stream100();
    logic acc;
    int   accepted, budget, recv0;
    accepted = 0; budget = 0; recv0 = nrecv;
    rnd_ops();
    while (accepted < 100 && budget < 4000) begin
      cyc(1'b1, ($urandom_range(1, 0) == 1), acc);
      if (acc) begin
        accepted++;
        rnd_ops();
      end
      budget++;
    end
    while (sb.size() > 0 && budget < 4000) begin
      cyc(1'b0, 1'b1, acc);
      budget++;
    end
    chk("stream_accepted", 64'(accepted), 64'd100);
    chk("stream_received", 64'(nrecv - recv0), 64'd100);
    chk("stream_sb_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic        acc;
    logic [63:0] m;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a_t = 64'd0; b_t = 64'd0; p_t = 64'd1; me_t = 1'b0;
    set_sel(0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      set_sel(k);
      #1;
      chk("rst_out_valid", 64'(ov_o), 64'd0);
      chk("rst_s", s_o, 64'd0);
      chk("rst_s_raw", raw_o, 64'd0);
      chk("rst_c_out", 64'(c_o), 64'd0);
      chk("rst_wrap", 64'(wr_o), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 3; k++) begin
      set_sel(k);
      m = mask_of(w_cur);
      directed(64'd5, 64'd7, 64'd11, 1'b1, 64'd1, 1'b1);
      directed(m, 64'd1, m, 1'b0, 64'd0, 1'b0);
      directed(m - 64'd5, m - 64'd5, m - 64'd4, 1'b1, m - 64'd6, 1'b1);
      directed(64'd3, 64'd8, 64'd11, 1'b1, 64'd0, 1'b1);
      directed(64'd3, 64'd7, 64'd11, 1'b1, 64'd10, 1'b0);
      stream100();
    end

    set_sel(0);
    for (int i = 0; i < 3; i++) begin
      rnd_ops();
      cyc(1'b1, 1'b1, acc);
    end
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(ov_o), 64'd0);
    chk("midrst_s", s_o, 64'd0);
    chk("midrst_wrap", 64'(wr_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    stall_prev = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("midrst_no_stale", 64'(ov_o), 64'd0);
      cyc(1'b0, 1'b1, acc);
    end
    directed(64'd5, 64'd7, 64'd11, 1'b1, 64'd1, 1'b1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
